// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;
    localparam logic [31:0] NOP             = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - priority mux for the pc register load value and enable
import fetch_pkg::*;

module pc_next_sel #(
    parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
    input  logic        rst,
    input  logic [31:0] pc_q,
    input  logic        seq_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    output logic        pc_en,
    output logic [31:0] pc_next
);

    // Exception beats branch redirect beats sequential step; wraps modulo 2^32.
    always_comb begin
        pc_en   = 1'b0;
        pc_next = pc_q + PC_STEP;
        if (exc_valid) begin
            pc_next = exc_pc;
        end else if (redirect_valid) begin
            pc_next = redirect_pc;
        end
        if (!rst) begin
            pc_en = exc_valid | redirect_valid | seq_en;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage fetch sequencer (optional FETCH_ALIGN_CHECK_EN)
import fetch_pkg::*;

module fetch_ctrl #(
    parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_q,
    output logic        pc_en,
    output logic [31:0] pc_next,
    input  logic        stall_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        if_adel,
`endif
    output logic [31:0] if_pc
);

    fetch_state_e state;
    logic [31:0]  req_addr;
    logic         drop;
    logic         flush;
    logic         accept;
    logic         misaligned;

    assign flush = redirect_valid | exc_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign inst_addr  = pc_q;
`else
    assign misaligned = 1'b0;
    assign inst_addr  = {pc_q[31:2], 2'b00};
`endif

    // A request is only offered in REQ for a fetchable address; the bridge acks only offered requests.
    always_comb begin
        inst_req = 1'b0;
        if (!rst && state == REQ && !misaligned) begin
            inst_req = 1'b1;
        end
    end

    assign accept = inst_req & inst_addr_ok;

    // An exception in HOLD flushes the presented instruction in the same cycle.
    assign if_valid = !rst && (state == HOLD) && !exc_valid;

    pc_next_sel #(
        .PC_STEP(PC_STEP)
    ) u_pc_next_sel (
        .rst           (rst),
        .pc_q          (pc_q),
        .seq_en        (accept),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .exc_valid     (exc_valid),
        .exc_pc        (exc_pc),
        .pc_en         (pc_en),
        .pc_next       (pc_next)
    );

    // Fetch FSM: issue, wait for response (squashing stale ones), then hold for decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= REQ;
            req_addr <= 32'h0;
            drop     <= 1'b0;
            if_inst  <= NOP;
            if_pc    <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            if_adel  <= 1'b0;
`endif
        end else begin
            case (state)
                REQ: begin
                    if (misaligned) begin
                        // A retarget this cycle wins; otherwise report the bad address to decode.
                        if (!flush) begin
                            state   <= HOLD;
                            if_inst <= NOP;
                            if_pc   <= pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
                            if_adel <= 1'b1;
`endif
                        end
                    end else if (accept) begin
                        req_addr <= pc_q;
                        drop     <= flush;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else if (flush) begin
                            state <= REQ;
                        end else begin
                            if_inst <= inst_rdata;
                            if_pc   <= req_addr;
`ifdef FETCH_ALIGN_CHECK_EN
                            if_adel <= 1'b0;
`endif
                            state   <= HOLD;
                        end
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (exc_valid || !stall_d) begin
                        state <= REQ;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        if_adel;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Stand-in for the external pc register.
    always_ff @(posedge clk) begin
        if (rst) pc_q <= 32'h0;
        else if (pc_en) pc_q <= pc_next;
    end

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .pc_q          (pc_q),
        .pc_en         (pc_en),
        .pc_next       (pc_next),
        .stall_d       (stall_d),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .exc_valid     (exc_valid),
        .exc_pc        (exc_pc),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .if_valid      (if_valid),
        .if_inst       (if_inst),
`ifdef FETCH_ALIGN_CHECK_EN
        .if_adel       (if_adel),
`endif
        .if_pc         (if_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive REQ (accepted) and WAIT (data returned); leaves the DUT entering HOLD.
    task automatic fetch_to_hold(input logic [31:0] addr, input logic [31:0] data);
        #1;
        chk("req_valid", {31'b0, inst_req}, 32'd1);
        chk("req_addr", inst_addr, addr);
        inst_addr_ok = 1'b1;
        #1;
        chk("req_pc_en", {31'b0, pc_en}, 32'd1);
        chk("req_pc_next", pc_next, addr + 32'd4);
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = data;
        #1;
        chk("wait_no_req", {31'b0, inst_req}, 32'd0);
        chk("wait_no_valid", {31'b0, if_valid}, 32'd0);
        tick();
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
    endtask

    task automatic hold_cycles(input logic [31:0] addr, input logic [31:0] data, input int n);
        for (int i = 0; i <= n; i++) begin
            stall_d = (i < n);
            #1;
            chk("hold_valid", {31'b0, if_valid}, 32'd1);
            chk("hold_inst", if_inst, data);
            chk("hold_pc", if_pc, addr);
            chk("hold_no_req", {31'b0, inst_req}, 32'd0);
            tick();
        end
        stall_d = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stall_d = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        exc_valid = 1'b0;
        exc_pc = 32'h0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'b0, inst_req}, 32'd0);
        chk("rst_pc_en", {31'b0, pc_en}, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        rst = 1'b0;

        // Back-to-back sequential fetches, three cycles each.
        fetch_to_hold(32'h0, 32'h1111_0000);
        hold_cycles(32'h0, 32'h1111_0000, 0);
        fetch_to_hold(32'h4, 32'h2222_0004);
        hold_cycles(32'h4, 32'h2222_0004, 0);

        // Redirect while waiting: the late response for 0x8 must be squashed.
        #1;
        chk("f8_addr", inst_addr, 32'h8);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("redir_pc_en", {31'b0, pc_en}, 32'd1);
        chk("redir_pc_next", pc_next, 32'h100);
        tick();
        redirect_valid = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata = 32'hDEAD_BEEF;
        #1;
        chk("drop_no_valid", {31'b0, if_valid}, 32'd0);
        tick();
        inst_data_ok = 1'b0;
        #1;
        chk("drop_after_valid", {31'b0, if_valid}, 32'd0);
        fetch_to_hold(32'h100, 32'h3333_0100);
        hold_cycles(32'h100, 32'h3333_0100, 0);

        // Redirect in REQ without acceptance only retargets the PC.
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        #1;
        chk("reqredir_req", {31'b0, inst_req}, 32'd1);
        chk("reqredir_pc_next", pc_next, 32'h10);
        tick();
        redirect_valid = 1'b0;
        fetch_to_hold(32'h10, 32'h1234_5678);
        hold_cycles(32'h10, 32'h1234_5678, 4);
        fetch_to_hold(32'h14, 32'h5555_0014);

        // Exception and redirect together in HOLD: exception wins, held instruction flushed.
        stall_d = 1'b1;
        exc_valid = 1'b1;
        exc_pc = 32'hBFC0_0380;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("exc_valid_gate", {31'b0, if_valid}, 32'd0);
        chk("exc_pc_next", pc_next, 32'hBFC0_0380);
        chk("exc_pc_en", {31'b0, pc_en}, 32'd1);
        tick();
        exc_valid = 1'b0;
        redirect_valid = 1'b0;
        stall_d = 1'b0;
        #1;
        chk("exc_after_valid", {31'b0, if_valid}, 32'd0);
        fetch_to_hold(32'hBFC0_0380, 32'h6666_0380);
        hold_cycles(32'hBFC0_0380, 32'h6666_0380, 0);

        // Wrap-around of the sequential step.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr", inst_addr, 32'hFFFF_FFFC);
        inst_addr_ok = 1'b1;
        #1;
        chk("wrap_pc_next", pc_next, 32'h0);
        tick();
        inst_addr_ok = 1'b0;

        // Exception coinciding with data: data discarded, no stale drop left behind.
        exc_valid = 1'b1;
        exc_pc = 32'h40;
        inst_data_ok = 1'b1;
        inst_rdata = 32'h7777_7777;
        tick();
        exc_valid = 1'b0;
        inst_data_ok = 1'b0;
        #1;
        chk("excdata_no_valid", {31'b0, if_valid}, 32'd0);
        fetch_to_hold(32'h40, 32'h8888_0040);
        hold_cycles(32'h40, 32'h8888_0040, 0);

        // Misaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        #1;
        chk("adel_no_req", {31'b0, inst_req}, 32'd0);
        tick();
        chk("adel_valid", {31'b0, if_valid}, 32'd1);
        chk("adel_flag", {31'b0, if_adel}, 32'd1);
        chk("adel_pc", if_pc, 32'h102);
        chk("adel_inst", if_inst, 32'h0);
`else
        #1;
        chk("align_req", {31'b0, inst_req}, 32'd1);
        chk("align_addr", inst_addr, 32'h100);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
